core_cluster_ctrl: RTL and testbench

Parametrised cluster controller for a multi-hart top level. It sequences reset release to NUM_CORES risc_core instances in staggered order and gates each hart with a run/halt control. It also arbitrates the harts' memory requests, round-robin, onto one shared single-outstanding memory port. It sits between the cluster top and the shared instruction/data memory.

---
 rtl/core_cluster_ctrl.sv | 172 +++++++++++++++++
 tb/tb_core_cluster_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_cluster_ctrl.sv
// rtl/core_cluster_ctrl.sv - staggered hart reset release, run/halt gating and round-robin memory arbiter
module core_cluster_ctrl #(
    parameter int NUM_CORES   = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int RST_STAGGER = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    halt_i,
    output logic [NUM_CORES-1:0]    core_rst_o,
    output logic                    all_released_o,
    input  logic [NUM_CORES-1:0]    core_req_valid_i,
    input  logic [NUM_CORES-1:0]    core_req_we_i,
    input  logic [NUM_CORES*AW-1:0] core_req_addr_i,
    input  logic [NUM_CORES*DW-1:0] core_req_wdata_i,
    output logic [NUM_CORES-1:0]    core_req_ready_o,
    output logic [NUM_CORES-1:0]    core_rsp_valid_o,
    output logic [DW-1:0]           core_rsp_rdata_o,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_req_we_o,
    output logic [AW-1:0]           mem_req_addr_o,
    output logic [DW-1:0]           mem_req_wdata_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [DW-1:0]           mem_rsp_rdata_i
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = $clog2(NUM_CORES * RST_STAGGER + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_CORES * RST_STAGGER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [NUM_CORES-1:0]    r_core_rst;
    logic                    r_all_released;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_gnt;
    logic                    r_mem_valid;
    logic                    r_mem_we;
    logic [AW-1:0]           r_mem_addr;
    logic [DW-1:0]           r_mem_wdata;
    logic [NUM_CORES-1:0]    r_rsp_valid;
    logic [DW-1:0]           r_rsp_rdata;

    logic [NUM_CORES-1:0]    w_elig;
    logic                    w_any;
    logic [IW-1:0]           w_pick;
    int                      w_idx;
    logic                    w_pick_we;
    logic [AW-1:0]           w_pick_addr;
    logic [DW-1:0]           w_pick_wdata;
    logic [IW-1:0]           w_ptr_next;

    // Hart i leaves reset one cycle after the counter reaches (i+1)*RST_STAGGER.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_core_rst     <= '1;
            r_all_released <= 1'b0;
        end else begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (r_cnt >= CW'((i + 1) * RST_STAGGER)) begin
                    r_core_rst[i] <= 1'b0;
                end
            end
            r_all_released <= (r_cnt >= CNT_MAX);
        end
    end

    assign w_elig = core_req_valid_i & ~r_core_rst & ~halt_i;

    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_CORES;
            if (!w_any && w_elig[w_idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(w_idx);
            end
        end
    end

    always_comb begin
        w_pick_we    = 1'b0;
        w_pick_addr  = '0;
        w_pick_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_pick == IW'(i)) begin
                w_pick_we    = core_req_we_i[i];
                w_pick_addr  = core_req_addr_i[i*AW +: AW];
                w_pick_wdata = core_req_wdata_i[i*DW +: DW];
            end
        end
    end

    assign w_ptr_next = (r_gnt == IW'(NUM_CORES - 1)) ? '0 : r_gnt + 1'b1;

    // Once granted, a transaction runs to completion regardless of halt or valid changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_pick;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= w_pick_we;
                        r_mem_addr  <= w_pick_addr;
                        r_mem_wdata <= w_pick_wdata;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        r_rsp_valid[r_gnt] <= 1'b1;
                        r_rsp_rdata        <= mem_rsp_rdata_i;
                        r_ptr              <= w_ptr_next;
                        r_state            <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        core_req_ready_o = '0;
        if (r_state == S_REQ && mem_req_ready_i) begin
            core_req_ready_o[r_gnt] = 1'b1;
        end
    end

    assign core_rst_o       = r_core_rst;
    assign all_released_o   = r_all_released;
    assign core_rsp_valid_o = r_rsp_valid;
    assign core_rsp_rdata_o = r_rsp_rdata;
    assign mem_req_valid_o  = r_mem_valid;
    assign mem_req_we_o     = r_mem_we;
    assign mem_req_addr_o   = r_mem_addr;
    assign mem_req_wdata_o  = r_mem_wdata;

endmodule

// File: tb/tb_core_cluster_ctrl.sv
// tb/tb_core_cluster_ctrl.sv - self-checking bench for core_cluster_ctrl
module tb_core_cluster_ctrl;

    localparam int NC = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ST = 4;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     halt_i;
    logic [NC-1:0]     core_rst_o;
    logic              all_released_o;
    logic [NC-1:0]     core_req_valid_i;
    logic [NC-1:0]     core_req_we_i;
    logic [NC*AW-1:0]  core_req_addr_i;
    logic [NC*DW-1:0]  core_req_wdata_i;
    logic [NC-1:0]     core_req_ready_o;
    logic [NC-1:0]     core_rsp_valid_o;
    logic [DW-1:0]     core_rsp_rdata_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [AW-1:0]     mem_req_addr_o;
    logic [DW-1:0]     mem_req_wdata_o;
    logic              mem_rsp_valid_i;
    logic [DW-1:0]     mem_rsp_rdata_i;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    core_cluster_ctrl #(.NUM_CORES(NC), .AW(AW), .DW(DW), .RST_STAGGER(ST)) dut (
        .clk              (clk),
        .rst              (rst),
        .halt_i           (halt_i),
        .core_rst_o       (core_rst_o),
        .all_released_o   (all_released_o),
        .core_req_valid_i (core_req_valid_i),
        .core_req_we_i    (core_req_we_i),
        .core_req_addr_i  (core_req_addr_i),
        .core_req_wdata_i (core_req_wdata_i),
        .core_req_ready_o (core_req_ready_o),
        .core_rsp_valid_o (core_rsp_valid_o),
        .core_rsp_rdata_o (core_rsp_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_we_o     (mem_req_we_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_wdata_o  (mem_req_wdata_o),
        .mem_rsp_valid_i  (mem_rsp_valid_i),
        .mem_rsp_rdata_i  (mem_rsp_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbiter: first requesting, non-halted hart at or after the pointer.
    function automatic int exp_gnt(input logic [1:0] v, input logic [1:0] h, input int p);
        int idx;
        for (int k = 0; k < NC; k++) begin
            idx = (p + k) % NC;
            if (v[idx] && !h[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        halt_i           = '0;
        core_req_valid_i = '0;
        core_req_we_i    = '0;
        core_req_addr_i  = '0;
        core_req_wdata_i = '0;
        mem_req_ready_i  = 1'b0;
        mem_rsp_valid_i  = 1'b0;
        mem_rsp_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (NC * ST + 3) @(negedge clk);
        m_ptr = 0;
    endtask

    // Plays one complete transaction as the memory and records what the DUT did.
    task automatic run_txn(
        input  logic [1:0]  v, input logic [1:0] we, input logic [1:0] hlt, input logic [1:0] hlt_wait,
        input  logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
        input  int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
        output int lat, output logic [31:0] o_addr, output logic o_we, output logic [31:0] o_wd,
        output int stable_bad, output logic [1:0] rdy_or, output int rdy_cnt,
        output logic [1:0] rsp_vec, output logic [31:0] rsp_data, output int rsp_cnt);
        lat = -1; o_addr = '0; o_we = 1'b0; o_wd = '0; stable_bad = 0;
        rdy_or = '0; rdy_cnt = 0; rsp_vec = '0; rsp_data = '0; rsp_cnt = 0;
        @(negedge clk);
        core_req_valid_i = v;
        core_req_we_i    = we;
        halt_i           = hlt;
        core_req_addr_i  = {a1, a0};
        core_req_wdata_i = {d1, d0};
        mem_req_ready_i  = 1'b0;
        mem_rsp_valid_i  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_req_valid_o) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            clear_inputs();
            return;
        end
        o_addr = mem_req_addr_o;
        o_we   = mem_req_we_o;
        o_wd   = mem_req_wdata_o;
        for (int k = 0; k < rdy_dly; k++) begin
            #1;
            if (core_req_ready_o != 0) rdy_cnt++;
            @(negedge clk);
            if (!mem_req_valid_o || mem_req_addr_o !== o_addr || mem_req_we_o !== o_we ||
                mem_req_wdata_o !== o_wd) stable_bad++;
        end
        mem_req_ready_i = 1'b1;
        #1;
        if (core_req_ready_o != 0) begin
            rdy_cnt++;
            rdy_or |= core_req_ready_o;
        end
        @(negedge clk);
        mem_req_ready_i  = 1'b0;
        core_req_valid_i = '0;
        halt_i           = hlt_wait;
        if (mem_req_valid_o) stable_bad++;
        for (int k = 0; k < rsp_dly; k++) begin
            @(negedge clk);
            if (core_rsp_valid_o != 0) rsp_cnt++;
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = rdata;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        if (core_rsp_valid_o != 0) begin
            rsp_cnt++;
            rsp_vec  = core_rsp_valid_o;
            rsp_data = core_rsp_rdata_o;
        end
        @(negedge clk);
        if (core_rsp_valid_o != 0) rsp_cnt++;
        halt_i = '0;
    endtask

    task automatic test_reset();
        logic [1:0] exp_rst;
        logic       exp_all;
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst_o !== 2'b11 || all_released_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
            mem_req_we_o !== 1'b0 || mem_req_addr_o !== '0 || mem_req_wdata_o !== '0 ||
            core_req_ready_o !== '0 || core_rsp_valid_o !== '0 || core_rsp_rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_values: rst=%b all=%b mv=%b addr=%h rsp=%b rdata=%h", core_rst_o,
                     all_released_o, mem_req_valid_o, mem_req_addr_o, core_rsp_valid_o, core_rsp_rdata_o);
        end
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) exp_rst[i] = !(c >= (i + 1) * ST + 1);
            exp_all = (c >= NC * ST + 1);
            checks++;
            if (core_rst_o !== exp_rst || all_released_o !== exp_all) begin
                errors++;
                $display("FAIL stagger_cycle%0d: got rst=%b all=%b expected rst=%b all=%b",
                         c, core_rst_o, all_released_o, exp_rst, exp_all);
            end
        end
        m_ptr = 0;
    endtask

    task automatic test_single_read();
        int lat, sb, rc, pc;
        logic [31:0] oa, ow, rd;
        logic we;
        logic [1:0] ro, rv;
        run_txn(2'b01, 2'b00, 2'b00, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 0, 0, 32'hDEADBEEF,
                lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
        checks++;
        if (oa !== 32'h100 || we !== 1'b0) begin
            errors++; $display("FAIL single_payload: got addr=%h we=%b expected addr=100 we=0", oa, we);
        end
        checks++;
        if (rc !== 1 || ro !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %0d pulses vec=%b expected 1 pulse vec=01", rc, ro);
        end
        checks++;
        if (pc !== 1 || rv !== 2'b01 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_rsp: got %0d pulses vec=%b data=%h expected 1 01 deadbeef", pc, rv, rd);
        end
        m_ptr = 1;
    endtask

    task automatic test_fairness();
        int lat, sb, rc, pc, g;
        logic [31:0] oa, ow, rd, a0, a1;
        logic we;
        logic [1:0] ro, rv;
        apply_reset();
        for (int t = 0; t < 6; t++) begin
            a0 = {16'h1000, 16'($urandom)};
            a1 = {16'h2000, 16'($urandom)};
            g  = exp_gnt(2'b11, 2'b00, m_ptr);
            run_txn(2'b11, 2'b00, 2'b00, 2'b00, a0, a1, 32'h0, 32'h0, 0, 0, $urandom,
                    lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
            checks++;
            if (g !== (t % 2) || rv !== (2'b01 << g) || oa !== (g == 0 ? a0 : a1)) begin
                errors++;
                $display("FAIL fairness_txn%0d: got rsp=%b addr=%h expected hart %0d", t, rv, oa, t % 2);
            end
            m_ptr = (g + 1) % NC;
        end
    endtask

    task automatic test_backpressure();
        int lat, sb, rc, pc;
        logic [31:0] oa, ow, rd;
        logic we;
        logic [1:0] ro, rv;
        run_txn(2'b10, 2'b10, 2'b00, 2'b00, 32'h0, 32'h3004, 32'h0, 32'hCAFE0001, 5, 2, 32'h0,
                lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
        checks++;
        if (sb !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", sb); end
        checks++;
        if (oa !== 32'h3004 || we !== 1'b1 || ow !== 32'hCAFE0001) begin
            errors++; $display("FAIL bp_payload: got addr=%h we=%b wd=%h expected 3004 1 cafe0001", oa, we, ow);
        end
        checks++;
        if (rc !== 1 || ro !== 2'b10 || pc !== 1 || rv !== 2'b10) begin
            errors++; $display("FAIL bp_handshake: got ready=%0d/%b rsp=%0d/%b expected 1/10 1/10", rc, ro, pc, rv);
        end
        m_ptr = 0;
    endtask

    task automatic test_halt();
        int lat, sb, rc, pc;
        logic [31:0] oa, ow, rd;
        logic we;
        logic [1:0] ro, rv;
        run_txn(2'b11, 2'b00, 2'b01, 2'b11, 32'h4000, 32'h5000, 32'h0, 32'h0, 0, 1, 32'h13572468,
                lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
        checks++;
        if (oa !== 32'h5000 || rv !== 2'b10 || rd !== 32'h13572468 || pc !== 1) begin
            errors++; $display("FAIL halt_mask: got addr=%h rsp=%b data=%h expected 5000 10 13572468", oa, rv, rd);
        end
        m_ptr = 0;
        run_txn(2'b11, 2'b00, 2'b11, 2'b00, 32'h4000, 32'h5000, 32'h0, 32'h0, 0, 0, 32'h0,
                lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
        checks++;
        if (lat !== -1) begin errors++; $display("FAIL halt_all: got latency %0d expected no request", lat); end
    endtask

    task automatic test_random();
        int lat, sb, rc, pc, g, rdl, rsl;
        logic [31:0] oa, ow, rd, a0, a1, d0, d1, rdat;
        logic we;
        logic [1:0] ro, rv, v, h, w;
        for (int t = 0; t < 25; t++) begin
            v = 2'($urandom); h = 2'($urandom_range(0, 3) == 0 ? $urandom : 0); w = 2'($urandom);
            a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom; rdat = $urandom;
            rdl = $urandom_range(0, 3); rsl = $urandom_range(0, 3);
            g = exp_gnt(v, h, m_ptr);
            run_txn(v, w, h, 2'($urandom), a0, a1, d0, d1, rdl, rsl, rdat,
                    lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
            checks++;
            if (g < 0) begin
                if (lat !== -1) begin
                    errors++; $display("FAIL random%0d_idle: got request latency %0d expected none", t, lat);
                end
            end else if (lat !== 1 || sb !== 0 || oa !== (g == 0 ? a0 : a1) || we !== w[g] ||
                         ow !== (g == 0 ? d0 : d1) || rc !== 1 || ro !== (2'b01 << g) ||
                         pc !== 1 || rv !== (2'b01 << g) || rd !== rdat) begin
                errors++;
                $display("FAIL random%0d: got lat=%0d addr=%h we=%b wd=%h rdy=%b rsp=%b data=%h expected hart %0d addr=%h data=%h",
                         t, lat, oa, we, ow, ro, rv, rd, g, (g == 0 ? a0 : a1), rdat);
            end
            if (g >= 0) m_ptr = (g + 1) % NC;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        core_req_valid_i = 2'b01;
        core_req_addr_i  = {32'h0, 32'h200};
        core_req_wdata_i = {32'h0, 32'h55AA55AA};
        core_req_we_i    = 2'b01;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req_valid_o) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_grant: got no request expected one"); end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i  = 1'b0;
        core_req_valid_i = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (core_rst_o !== 2'b11 || all_released_o !== 1'b0 || mem_req_valid_o !== 1'b0 ||
            mem_req_we_o !== 1'b0 || mem_req_addr_o !== '0 || mem_req_wdata_o !== '0 ||
            core_req_ready_o !== '0 || core_rsp_valid_o !== '0 || core_rsp_rdata_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: rst=%b all=%b mv=%b addr=%h wd=%h rdata=%h", core_rst_o,
                     all_released_o, mem_req_valid_o, mem_req_addr_o, mem_req_wdata_o, core_rsp_rdata_o);
        end
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        checks++;
        if (core_rsp_valid_o !== '0) begin errors++; $display("FAIL mid_late_rsp: got %b expected 00", core_rsp_valid_o); end
        @(negedge clk);
        checks++;
        if (core_rsp_valid_o !== '0 || core_rst_o !== 2'b11) begin
            errors++; $display("FAIL mid_restart: got rsp=%b rst=%b expected 00 11", core_rsp_valid_o, core_rst_o);
        end
        repeat (NC * ST + 2) @(negedge clk);
        checks++;
        if (core_rst_o !== 2'b00 || all_released_o !== 1'b1) begin
            errors++; $display("FAIL mid_rerelease: got rst=%b all=%b expected 00 1", core_rst_o, all_released_o);
        end
        m_ptr = 0;
    endtask

    task automatic test_back_to_back();
        int lat, sb, rc, pc;
        logic [31:0] oa, ow, rd;
        logic we;
        logic [1:0] ro, rv;
        for (int t = 0; t < 2; t++) begin
            run_txn(2'b11, 2'b00, 2'b00, 2'b00, 32'h600, 32'h700, 32'h0, 32'h0, 0, 0, 32'h77 + t,
                    lat, oa, we, ow, sb, ro, rc, rv, rd, pc);
            checks++;
            if (rv !== (2'b01 << t) || rd !== 32'h77 + t || lat !== 1) begin
                errors++; $display("FAIL b2b%0d: got rsp=%b data=%h lat=%0d expected hart %0d", t, rv, rd, lat, t);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_backpressure();
        test_halt();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
